// File: rtl/i2c_reg_sequencer_if.sv
// Host request/response channel plus the byte-command channel to the I2C master.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface i2c_reg_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_rw;
   logic [6:0] req_dev;
   logic [7:0] req_reg;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic       m_cmd_valid;
   logic       m_cmd_ready;
   logic [1:0] m_cmd;
   logic [7:0] m_wdata;
   logic       m_done;
   logic       m_ack;
   logic [7:0] m_rdata;
   logic       m_abort;

   // valid/ready: a transfer happens on every clock edge where both are high; the
   // sender keeps valid and its payload stable until that edge.
   modport slave (
      input  req_valid, req_rw, req_dev, req_reg, req_wdata, rsp_ready,
             m_cmd_ready, m_done, m_ack, m_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, m_cmd_valid, m_cmd,
             m_wdata, m_abort
   );

   modport master (
      output req_valid, req_rw, req_dev, req_reg, req_wdata, rsp_ready,
             m_cmd_ready, m_done, m_ack, m_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_cmd_valid, m_cmd,
             m_wdata, m_abort
   );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write request into the START/WRITE/READ/STOP byte-command
// sequence for the I2C master, with NACK abort, command timeout and one response per request.
module i2c_reg_sequencer #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   i2c_reg_sequencer_if.slave        bus,
   output logic [2:0]                dbg_state_o
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_ISSUE      = 3'd1;
   localparam logic [2:0] S_WAIT       = 3'd2;
   localparam logic [2:0] S_ABORT_STOP = 3'd3;
   localparam logic [2:0] S_RESP       = 3'd4;

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_STOP  = 2'b11;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_NACK    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]      state_q, state_d;
   logic [2:0]      step_q, step_d;
   logic            rw_q, rw_d;
   logic [6:0]      dev_q, dev_d;
   logic [7:0]      reg_q, reg_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      rdata_q, rdata_d;
   logic [1:0]      err_q, err_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            abort_q, abort_d;

   logic [1:0]      cur_cmd;
   logic [7:0]      cur_byte;
   logic [2:0]      last_step;
   logic            cmd_valid;

   // Command for the current step; any step past the data phase is STOP.
   always_comb begin
      cur_cmd  = CMD_STOP;
      cur_byte = 8'h00;
      case (step_q)
         3'd0: begin
            cur_cmd  = CMD_START;
            cur_byte = {dev_q, 1'b0};
         end
         3'd1: begin
            cur_cmd  = CMD_WRITE;
            cur_byte = reg_q;
         end
         3'd2: begin
            if (rw_q) begin
               cur_cmd  = CMD_START;
               cur_byte = {dev_q, 1'b1};
            end else begin
               cur_cmd  = CMD_WRITE;
               cur_byte = wdata_q;
            end
         end
         3'd3: begin
            if (rw_q) cur_cmd = CMD_READ;
         end
         default: ;
      endcase
   end

   assign last_step = rw_q ? 3'd4 : 3'd3;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      rw_d    = rw_q;
      dev_d   = dev_q;
      reg_d   = reg_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      abort_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               rw_d    = bus.req_rw;
               dev_d   = bus.req_dev;
               reg_d   = bus.req_reg;
               wdata_d = bus.req_wdata;
               step_d  = 3'd0;
               rdata_d = 8'h00;
               err_d   = ERR_OK;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE, S_ABORT_STOP: begin
            if (bus.m_cmd_ready) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // m_done takes priority over a timeout landing in the same cycle.
            if (bus.m_done) begin
               if ((cur_cmd == CMD_START || cur_cmd == CMD_WRITE) && !bus.m_ack) begin
                  err_d   = ERR_NACK;
                  step_d  = last_step;
                  state_d = S_ABORT_STOP;
               end else if (cur_cmd == CMD_STOP) begin
                  state_d = S_RESP;
               end else begin
                  if (cur_cmd == CMD_READ) rdata_d = bus.m_rdata;
                  step_d  = step_q + 3'd1;
                  state_d = S_ISSUE;
               end
            end else if (cnt_q == TO_LAST) begin
               abort_d = 1'b1;
               err_d   = ERR_TIMEOUT;
               rdata_d = 8'h00;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         step_q  <= 3'd0;
         rw_q    <= 1'b0;
         dev_q   <= 7'h00;
         reg_q   <= 8'h00;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         err_q   <= ERR_OK;
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         rw_q    <= rw_d;
         dev_q   <= dev_d;
         reg_q   <= reg_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   // Command payload is zeroed whenever no command is offered.
   assign cmd_valid       = (state_q == S_ISSUE) || (state_q == S_ABORT_STOP);
   assign bus.m_cmd_valid = cmd_valid;
   assign bus.m_cmd       = cmd_valid ? cur_cmd : 2'b00;
   assign bus.m_wdata     = cmd_valid ? cur_byte : 8'h00;
   assign bus.m_abort     = abort_q;
   assign bus.req_ready   = (state_q == S_IDLE);
   assign bus.rsp_valid   = (state_q == S_RESP);
   assign bus.rsp_rdata   = rdata_q;
   assign bus.rsp_err     = err_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Randomized bench for i2c_reg_sequencer: host driver, byte-level master model and a
// scoreboard fed by a transaction-level reference of the expected command stream.
module tb_i2c_reg_sequencer;
   localparam int TIMEOUT = 16;

   logic       clk;
   logic       reset;
   logic [2:0] dbg_state;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   i2c_reg_sequencer_if bus ();

   i2c_reg_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog expired act=running req=finished");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   logic [10:0] exp_cmd_q[$];   // {check_byte, cmd, byte}
   logic [9:0]  exp_rsp_q[$];   // {err, rdata}
   logic [0:0]  exp_abort_q[$];

   // master-model plan for the current transaction
   int         txn_id = 0;
   int         nack_idx = -1;
   int         tmo_idx = -1;
   int         late_idx = -1;
   int         hold_idx = -1;
   logic [7:0] rd_val = 8'h00;
   logic       held = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s act=event req=none t=%0t", nm, $time);
   endtask

   // Reference: the command list follows directly from the request; a NACK truncates
   // it and appends STOP, a timeout truncates it with no STOP.
   function automatic void model_push(input logic rw, input logic [6:0] dev,
                                      input logic [7:0] rg, input logic [7:0] wd,
                                      input int nk, input int tm, input logic [7:0] rd);
      logic [10:0] seq[$];
      int last;
      seq.push_back({1'b1, 2'b00, dev, 1'b0});
      seq.push_back({1'b1, 2'b01, rg});
      if (rw) begin
         seq.push_back({1'b1, 2'b00, dev, 1'b1});
         seq.push_back({1'b0, 2'b10, 8'h00});
      end else begin
         seq.push_back({1'b1, 2'b01, wd});
      end
      seq.push_back({1'b0, 2'b11, 8'h00});
      last = (nk >= 0) ? nk : (tm >= 0) ? tm : seq.size() - 1;
      for (int i = 0; i <= last; i++) exp_cmd_q.push_back(seq[i]);
      if (nk >= 0) begin
         exp_cmd_q.push_back({1'b0, 2'b11, 8'h00});
         exp_rsp_q.push_back({2'b01, 8'h00});
      end else if (tm >= 0) begin
         exp_abort_q.push_back(1'b1);
         exp_rsp_q.push_back({2'b10, 8'h00});
      end else begin
         exp_rsp_q.push_back({2'b00, rw ? rd : 8'h00});
      end
   endfunction

   // ---------------- host driver tasks ----------------
   task automatic prep(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd, input int nk, input int tm, input int lt,
                       input int hd, input logic [7:0] rd);
      nack_idx = nk;
      tmo_idx  = tm;
      late_idx = lt;
      hold_idx = hd;
      rd_val   = rd;
      txn_id++;
      model_push(rw, dev, rg, wd, nk, tm, rd);
      bus.req_rw    = rw;
      bus.req_dev   = dev;
      bus.req_reg   = rg;
      bus.req_wdata = wd;
   endtask

   task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input int nk, input int tm, input int lt,
                           input int hd, input logic [7:0] rd);
      int n = 0;
      @(negedge clk);
      prep(rw, dev, rg, wd, nk, tm, lt, hd, rd);
      bus.req_valid = 1'b1;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) fail("req_accept_timeout");
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int dly);
      int n = 0;
      while (!bus.rsp_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_arrive", bus.rsp_valid, 1);
      if (bus.rsp_valid) begin
         repeat (dly) @(negedge clk);
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
      end
   endtask

   task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input int nk, input int tm, input int lt,
                          input logic [7:0] rd, input int rdly);
      send_req(rw, dev, rg, wd, nk, tm, lt, -1, rd);
      wait_rsp(rdly);
   endtask

   // ---------------- byte-level master model ----------------
   initial begin : master_drv
      int seen_id;
      int idx;
      int n;
      int dly;
      logic [1:0] c;
      seen_id = -1;
      idx = 0;
      bus.m_cmd_ready = 1'b0;
      bus.m_done      = 1'b0;
      bus.m_ack       = 1'b0;
      bus.m_rdata     = 8'h00;
      forever begin
         @(negedge clk);
         bus.m_done = 1'b0;
         if (reset) continue;
         if (bus.m_cmd_valid) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (reset) continue;
            bus.m_cmd_ready = 1'b1;
            c = bus.m_cmd;
            if (seen_id != txn_id) begin
               seen_id = txn_id;
               idx = 0;
            end
            @(negedge clk);
            bus.m_cmd_ready = 1'b0;
            if (reset) continue;
            if (idx == tmo_idx || idx == hold_idx) begin
               held = 1'b1;
               n = 0;
               while (!bus.m_abort && !reset && n < 200) begin
                  @(negedge clk);
                  n++;
               end
               held = 1'b0;
            end else begin
               dly = (idx == late_idx) ? TIMEOUT - 1 : $urandom_range(0, 3);
               repeat (dly) @(negedge clk);
               bus.m_done  = 1'b1;
               bus.m_ack   = (c == 2'b10 || c == 2'b11) ? 1'($urandom_range(0, 1))
                                                         : (idx != nack_idx);
               bus.m_rdata = (c == 2'b10) ? rd_val : 8'($urandom);
               @(negedge clk);
               bus.m_done = 1'b0;
            end
            idx++;
         end else if ((bus.req_ready || bus.rsp_valid) && $urandom_range(0, 7) == 0) begin
            // stray completion while no command is outstanding
            bus.m_done  = 1'b1;
            bus.m_ack   = 1'($urandom_range(0, 1));
            bus.m_rdata = 8'($urandom);
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [10:0] e;
      logic [9:0]  r;
      logic        p_cv, p_cr, p_rv, p_rr;
      logic [9:0]  p_cmd, p_rsp;
      int          hs_cyc;
      p_cv = 0; p_cr = 0; p_rv = 0; p_rr = 0;
      p_cmd = 0; p_rsp = 0; hs_cyc = 0;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            p_cv = 0;
            p_rv = 0;
            continue;
         end
         if (p_cv && !p_cr) begin
            chk("cmd_hold_valid", bus.m_cmd_valid, 1);
            chk("cmd_hold_payload", {bus.m_cmd, bus.m_wdata}, p_cmd);
         end
         if (p_rv && !p_rr) begin
            chk("rsp_hold_valid", bus.rsp_valid, 1);
            chk("rsp_hold_payload", {bus.rsp_err, bus.rsp_rdata}, p_rsp);
         end
         if (bus.m_cmd_valid && bus.m_cmd_ready) begin
            hs_cyc = cyc + 1;
            if (exp_cmd_q.size() == 0) fail("cmd_unexpected");
            else begin
               e = exp_cmd_q.pop_front();
               chk("cmd_code", bus.m_cmd, e[9:8]);
               if (e[10]) chk("cmd_byte", bus.m_wdata, e[7:0]);
            end
         end
         if (bus.m_abort) begin
            if (exp_abort_q.size() == 0) fail("abort_unexpected");
            else begin
               void'(exp_abort_q.pop_front());
               chk("abort_latency", cyc - hs_cyc, TIMEOUT);
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_rsp_q.size() == 0) fail("rsp_unexpected");
            else begin
               r = exp_rsp_q.pop_front();
               chk("rsp_err", bus.rsp_err, r[9:8]);
               chk("rsp_rdata", bus.rsp_rdata, r[7:0]);
            end
         end
         p_cv = bus.m_cmd_valid;
         p_cr = bus.m_cmd_ready;
         p_cmd = {bus.m_cmd, bus.m_wdata};
         p_rv = bus.rsp_valid;
         p_rr = bus.rsp_ready;
         p_rsp = {bus.rsp_err, bus.rsp_rdata};
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 1);
      chk({tag, "_m_cmd_valid"}, bus.m_cmd_valid, 0);
      chk({tag, "_m_cmd"}, bus.m_cmd, 0);
      chk({tag, "_m_wdata"}, bus.m_wdata, 0);
      chk({tag, "_m_abort"}, bus.m_abort, 0);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
      chk({tag, "_rsp_err"}, bus.rsp_err, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int n;
      logic rw;
      int sc, len, nk, tm, lt;
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_rw    = 1'b0;
      bus.req_dev   = 7'h00;
      bus.req_reg   = 8'h00;
      bus.req_wdata = 8'h00;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b0;

      run_txn(1'b0, 7'h50, 8'h10, 8'hA5, -1, -1, -1, 8'h00, 0);
      run_txn(1'b1, 7'h50, 8'h20, 8'h00, -1, -1, -1, 8'h3C, 1);
      run_txn(1'b0, 7'h50, 8'h10, 8'h55, 0, -1, -1, 8'h00, 0);
      run_txn(1'b0, 7'h50, 8'h11, 8'h66, -1, 1, -1, 8'h00, 2);
      run_txn(1'b1, 7'h21, 8'h30, 8'h00, -1, -1, 3, 8'h99, 0);
      run_txn(1'b0, 7'h33, 8'h44, 8'h77, -1, -1, 1, 8'h00, 0);

      // response stall with a new request pending
      send_req(1'b1, 7'h12, 8'h34, 8'h00, -1, -1, -1, -1, 8'h5A);
      n = 0;
      while (!bus.rsp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("stall_rsp_arrive", bus.rsp_valid, 1);
      prep(1'b0, 7'h45, 8'h67, 8'h89, -1, -1, -1, -1, 8'h00);
      bus.req_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("stall_req_ready_low", bus.req_ready, 0);
         chk("stall_rsp_valid", bus.rsp_valid, 1);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("stall_idle_next", bus.req_ready, 1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("stall_accepted", bus.req_ready, 0);
      wait_rsp(0);

      // reset while waiting on step 2
      send_req(1'b0, 7'h50, 8'h01, 8'hC3, -1, -1, -1, 2, 8'h00);
      n = 0;
      while (!held && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("hold_reached", held, 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      exp_cmd_q.delete();
      exp_rsp_q.delete();
      exp_abort_q.delete();
      #1;
      chk_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run_txn(1'b1, 7'h50, 8'h02, 8'h00, -1, -1, -1, 8'hE7, 0);

      for (int t = 0; t < 40; t++) begin
         rw  = 1'($urandom_range(0, 1));
         sc  = $urandom_range(0, 19);
         len = rw ? 5 : 4;
         nk = -1;
         tm = -1;
         lt = -1;
         if (sc < 3) nk = $urandom_range(0, 2);
         else if (sc < 5) tm = $urandom_range(0, len - 1);
         else if (sc < 7) lt = $urandom_range(0, len - 1);
         run_txn(rw, 7'($urandom), 8'($urandom), 8'($urandom), nk, tm, lt,
                 8'($urandom), $urandom_range(0, 3));
      end

      repeat (20) @(negedge clk);
      chk("cmd_queue_drained", exp_cmd_q.size(), 0);
      chk("rsp_queue_drained", exp_rsp_q.size(), 0);
      chk("abort_queue_drained", exp_abort_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
